control_seq: RTL and testbench
==============================

Name: control_seq

Overview:
- Parametrised multi-cycle successor to the single-cycle nic8 control decoder.
- Owns the instruction register and a FETCH/EXEC sequencer with a memory-ready handshake.
- Decodes the dest/source fields to one-hot active-low strobes of configurable width and resolves conditional jumps against flags latched at the EXEC→FETCH boundary.
- Sits between the program ROM/bus and the register file/ALU; it replaces the combinational decoder plus its clock-gated triggers.

Parameters:
- DEST_BITS, 3, width of the destination field; number of load strobes = 2**DEST_BITS.
- SRC_BITS, 3, width of the source field; number of assert strobes = 2**SRC_BITS.
- PC_DEST, 1, destination code that denotes a program-counter load (jump).
- HALT_DEST, 7, destination code used as HALT when CONTROL_HALT_EN is defined.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- resetBar  input  1  asynchronous active-low reset.
- irIn  input  IW  instruction byte from the bus; IW = DEST_BITS+SRC_BITS+2.
- memReady  input  1  high when irIn is valid during FETCH.
- aIsZero  input  1  live zero flag from the A register.
- flagCarry  input  1  live ALU carry.
- flagShift  input  1  live shifter output bit.
- run  input  1  restarts from HALT (used only with CONTROL_HALT_EN).
- fetching  output  1  high in FETCH state.
- assertRomBar  output  1  low in FETCH (ROM drives bus).
- incPC  output  1  one-cycle pulse on the FETCH accept edge.
- loadBar  output  2**DEST_BITS  one-hot active-low load strobes, EXEC only.
- assertBar  output  2**SRC_BITS  one-hot active-low bus-source strobes, EXEC only.
- trigger  output  2**DEST_BITS  one-cycle active-high register clock-enables, last EXEC cycle.
- doSubtract  output  1  IR bit SRC_BITS (the "bit3" field); also doShiftIn.
- doCarryIn  output  1  IR msb (the "bit7" field).
- doJumpBar  output  1  low in EXEC when dest==PC_DEST and the condition is true.
- halted  output  1  high in HALT state.
- retired  output  CNT_W  count of completed EXEC cycles.

Behaviour:
- Field split, msb first: {bit7, dest[DEST_BITS], bit3, src[SRC_BITS]}.
- Reset (async, resetBar low):
  - state=FETCH; IR=0; flag latch=0; retired=0; incPC=0; halted=0.
  - All loadBar/assertBar bits high; trigger=0; doJumpBar=1.
- FETCH:
  - assertRomBar=0, fetching=1; every other strobe is inactive.
  - memReady=0 → stay in FETCH (wait states unbounded); no IR change, no incPC.
  - memReady=1 → IR<=irIn, incPC=1 for exactly that cycle, next state EXEC.
- EXEC (exactly one cycle):
  - assertBar[src]=0 and loadBar[dest]=0, decoded from the registered IR.
  - dest==PC_DEST: condition cond = {bit7,bit3}: 00→1, 01→zL, 10→cL, 11→sL, where zL/cL/sL are the latched flags.
    - cond=1 → loadBar[PC_DEST]=0, doJumpBar=0, trigger[PC_DEST]=1.
    - cond=0 → loadBar[PC_DEST]=1, doJumpBar=1, trigger[PC_DEST]=0.
  - Other dests: trigger[dest]=1 for the EXEC cycle.
  - On the EXEC edge: flag latch <= {aIsZero, flagCarry, flagShift}; retired <= retired+1, wrapping modulo 2**CNT_W; next state FETCH.
- Flags used by a jump are therefore those present at the end of the previous instruction. Flags at reset are 0, so a conditional jump as the first instruction is not taken.
- Source code 1 (the zero source) asserts assertBar[1]=0; the bus keeper supplies zero.
- trigger is registered-free combinational decode of state+IR. Glitch-free because IR only changes while trigger=0 (FETCH).
- Reset mid-EXEC aborts the instruction: no trigger edge and no retired increment.

Optional Feature:
- Macro CONTROL_HALT_EN.
- Defined:
  - dest==HALT_DEST in EXEC asserts no loadBar/trigger, still counts as retired, and enters HALT.
  - HALT: fetching=0, all strobes inactive, halted=1, IR held.
  - run=1 on a clock edge → FETCH.
  - Reset also leaves HALT.
- Undefined: HALT_DEST is an ordinary destination strobe; halted is tied 0; run is ignored.

Test Plan:
- Reset with resetBar=0 mid-EXEC → all loadBar/assertBar=all-ones, trigger=0, retired=0, state FETCH on the next cycle.
- irIn=0x23 (dest 2=A, src 3=B), memReady=1 → next cycle loadBar=~0x04, assertBar=~0x08, trigger=0x04, retired=1.
- memReady held low 3 cycles then high → 3 wait cycles with assertRomBar=0, incPC pulses once, IR loaded only on the ready edge.
- Previous instruction ends with aIsZero=1, then irIn=0x18 (dest PC, cond zero) → doJumpBar=0, trigger[1]=1. Repeat with aIsZero=0 at end of prior instruction → doJumpBar=1, trigger=0.
- 2**CNT_W instructions executed → retired wraps to 0.
- CONTROL_HALT_EN defined, irIn=0x70 → halted=1 and no strobes until run=1, then FETCH resumes. Without the macro, the same opcode gives loadBar[7]=0 and halted=0.

Source files
------------

// File: rtl/control_seq.sv
// control_seq: FETCH/EXEC sequencer owning the IR, with one-hot strobe decode.
// Define CONTROL_HALT_EN to make HALT_DEST enter a HALT state released by run.
module control_seq #(
    parameter int DEST_BITS = 3,
    parameter int SRC_BITS  = 3,
    parameter int PC_DEST   = 1,
    parameter int HALT_DEST = 7,
    parameter int CNT_W     = 16,
    localparam int IW = DEST_BITS + SRC_BITS + 2,
    localparam int ND = 2 ** DEST_BITS,
    localparam int NS = 2 ** SRC_BITS
) (
    input  logic             clk,
    input  logic             resetBar,
    input  logic [IW-1:0]    irIn,
    input  logic             memReady,
    input  logic             aIsZero,
    input  logic             flagCarry,
    input  logic             flagShift,
    input  logic             run,
    output logic             fetching,
    output logic             assertRomBar,
    output logic             incPC,
    output logic [ND-1:0]    loadBar,
    output logic [NS-1:0]    assertBar,
    output logic [ND-1:0]    trigger,
    output logic             doSubtract,
    output logic             doCarryIn,
    output logic             doJumpBar,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [DEST_BITS-1:0] PC_CODE   = DEST_BITS'(PC_DEST);
    localparam logic [DEST_BITS-1:0] HALT_CODE = DEST_BITS'(HALT_DEST);

    state_t           state_q, state_d;
    logic [IW-1:0]    ir_q, ir_d;
    logic [2:0]       flags_q, flags_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    logic                 bit7, bit3;
    logic [DEST_BITS-1:0] dest;
    logic [SRC_BITS-1:0]  src;
    logic [ND-1:0]        dest_oh;
    logic [NS-1:0]        src_oh;
    logic                 exec, is_pc, dest_is_halt, is_halt;
    logic                 cond, load_en;

    assign bit7 = ir_q[IW-1];
    assign dest = ir_q[IW-2 -: DEST_BITS];
    assign bit3 = ir_q[SRC_BITS];
    assign src  = ir_q[SRC_BITS-1:0];

    assign exec         = (state_q == S_EXEC);
    assign is_pc        = (dest == PC_CODE);
    assign dest_is_halt = (dest == HALT_CODE);

`ifdef CONTROL_HALT_EN
    assign is_halt = dest_is_halt;
    assign halted  = (state_q == S_HALT);
`else
    logic unused_halt_in;
    assign unused_halt_in = run ^ dest_is_halt;
    assign is_halt = 1'b0;
    assign halted  = 1'b0;
`endif

    // Flag latch order is {zero, carry, shift}.
    always_comb begin
        cond = 1'b1;
        unique case ({bit7, bit3})
            2'b00: cond = 1'b1;
            2'b01: cond = flags_q[2];
            2'b10: cond = flags_q[1];
            2'b11: cond = flags_q[0];
            default: cond = 1'b1;
        endcase
    end

    assign dest_oh = ND'(1) << dest;
    assign src_oh  = NS'(1) << src;
    assign load_en = exec & ~is_halt & (~is_pc | cond);

    assign trigger      = load_en ? dest_oh : '0;
    assign loadBar      = ~trigger;
    assign assertBar    = exec ? ~src_oh : '1;
    assign doJumpBar    = ~(exec & is_pc & cond);
    assign fetching     = (state_q == S_FETCH);
    assign assertRomBar = ~fetching;
    assign incPC        = fetching & memReady & resetBar;
    assign doSubtract   = bit3;
    assign doCarryIn    = bit7;
    assign retired      = retired_q;

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        flags_d   = flags_q;
        retired_d = retired_q;
        unique case (state_q)
            S_FETCH: begin
                if (memReady) begin
                    ir_d    = irIn;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                flags_d   = {aIsZero, flagCarry, flagShift};
                retired_d = retired_q + CNT_W'(1);
                state_d   = is_halt ? S_HALT : S_FETCH;
            end
            S_HALT: begin
`ifdef CONTROL_HALT_EN
                if (run) state_d = S_FETCH;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            state_q   <= S_FETCH;
            ir_q      <= '0;
            flags_q   <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            flags_q   <= flags_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_control_seq.sv
// tb_control_seq: random and directed stimulus checked against a
// behavioural instruction-level model of control_seq.
module tb_control_seq;
    localparam int CW   = 8;
    localparam int RMOD = 1 << CW;
`ifdef CONTROL_HALT_EN
    localparam int HALT_EN = 1;
`else
    localparam int HALT_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          resetBar, memReady, aIsZero, flagCarry, flagShift, run;
    logic [7:0]    irIn;
    logic          fetching, assertRomBar, incPC;
    logic [7:0]    loadBar, assertBar, trigger;
    logic          doSubtract, doCarryIn, doJumpBar, halted;
    logic [CW-1:0] retired;

    int n_tests = 0;
    int n_fail  = 0;
    // model: phase 0=fetch 1=exec 2=halt
    int m_phase, m_ir, mz, mc, ms, m_ret;

    control_seq #(.CNT_W(CW)) dut (
        .clk(clk), .resetBar(resetBar), .irIn(irIn), .memReady(memReady),
        .aIsZero(aIsZero), .flagCarry(flagCarry), .flagShift(flagShift),
        .run(run), .fetching(fetching), .assertRomBar(assertRomBar),
        .incPC(incPC), .loadBar(loadBar), .assertBar(assertBar),
        .trigger(trigger), .doSubtract(doSubtract), .doCarryIn(doCarryIn),
        .doJumpBar(doJumpBar), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ir = 0; mz = 0; mc = 0; ms = 0; m_ret = 0;
    endtask

    task automatic update_model();
        int dst;
        dst = (m_ir >> 4) & 7;
        case (m_phase)
            0: if (memReady) begin m_ir = int'(irIn); m_phase = 1; end
            1: begin
                mz = int'(aIsZero); mc = int'(flagCarry); ms = int'(flagShift);
                m_ret = (m_ret + 1) % RMOD;
                m_phase = (HALT_EN == 1 && dst == 7) ? 2 : 0;
            end
            default: if (run) m_phase = 0;
        endcase
    endtask

    task automatic check_model();
        int dst, sr, sel, cnd, ex, taken, e_trig, e_as, e_jb;
        dst = (m_ir >> 4) & 7;
        sr  = m_ir & 7;
        sel = ((m_ir >> 7) & 1) * 2 + ((m_ir >> 3) & 1);
        cnd = (sel == 0) ? 1 : (sel == 1) ? mz : (sel == 2) ? mc : ms;
        ex  = (m_phase == 1) ? 1 : 0;
        taken = (ex == 1) && !(HALT_EN == 1 && dst == 7) && (dst != 1 || cnd == 1);
        e_trig = taken ? (1 << dst) : 0;
        e_as   = ex ? (255 ^ (1 << sr)) : 255;
        e_jb   = (ex == 1 && dst == 1 && cnd == 1) ? 0 : 1;
        chk("m_fetching", fetching, m_phase == 0);
        chk("m_romBar", assertRomBar, m_phase != 0);
        chk("m_incPC", incPC, m_phase == 0 && memReady && resetBar);
        chk("m_trigger", trigger, e_trig);
        chk("m_loadBar", loadBar, 255 ^ e_trig);
        chk("m_assertBar", assertBar, e_as);
        chk("m_jumpBar", doJumpBar, e_jb);
        chk("m_sub", doSubtract, (m_ir >> 3) & 1);
        chk("m_carryIn", doCarryIn, (m_ir >> 7) & 1);
        chk("m_halted", halted, m_phase == 2);
        chk("m_retired", retired, m_ret);
    endtask

    task automatic drive(input logic [7:0] ir, input logic rdy,
                         input logic z, input logic c, input logic s,
                         input logic rn);
        irIn = ir; memReady = rdy;
        aIsZero = z; flagCarry = c; flagShift = s; run = rn;
    endtask

    task automatic cycle();
        #1 check_model();
        @(posedge clk);
        if (resetBar) update_model();
        else model_reset();
        @(negedge clk);
    endtask

    initial begin
        resetBar = 1'b0;
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_loadBar", loadBar, 8'hFF);
        chk("rst_assertBar", assertBar, 8'hFF);
        chk("rst_trigger", trigger, 8'h00);
        chk("rst_retired", retired, 0);
        chk("rst_incPC", incPC, 1'b0);
        chk("rst_jumpBar", doJumpBar, 1'b1);
        chk("rst_fetching", fetching, 1'b1);
        check_model();
        @(negedge clk);
        resetBar = 1'b1;

        // first instruction is a zero-conditional jump: flags are 0
        drive(8'h18, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("jmp_first_nt", doJumpBar, 1'b1);
        chk("jmp_first_trig", trigger, 8'h00);
        cycle();

        // reset in the middle of EXEC
        drive(8'h23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        #2 resetBar = 1'b0;
        model_reset();
        #1;
        chk("mid_loadBar", loadBar, 8'hFF);
        chk("mid_assertBar", assertBar, 8'hFF);
        chk("mid_trigger", trigger, 8'h00);
        chk("mid_retired", retired, 0);
        cycle();
        resetBar = 1'b1;
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        #1 chk("mid_fetch", fetching, 1'b1);

        // plain A <- B
        drive(8'h23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("ab_incPC", incPC, 1'b1);
        cycle();
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("ab_loadBar", loadBar, 8'hFB);
        chk("ab_assertBar", assertBar, 8'hF7);
        chk("ab_trigger", trigger, 8'h04);
        cycle();
        #1 chk("ab_retired", retired, 1);

        // three wait states
        for (int i = 0; i < 3; i++) begin
            drive(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            #1 chk("ws_romBar", assertRomBar, 1'b0);
            chk("ws_incPC", incPC, 1'b0);
            cycle();
        end
        drive(8'h45, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("ws_incPC_rdy", incPC, 1'b1);
        cycle();
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("ws_incPC_once", incPC, 1'b0);
        chk("ws_loadBar", loadBar, 8'hEF);
        chk("ws_assertBar", assertBar, 8'hDF);
        cycle();

        // jump-if-zero, taken then not taken
        drive(8'h23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(8'h18, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        #1 chk("jz_t_jumpBar", doJumpBar, 1'b0);
        chk("jz_t_trigger", trigger, 8'h02);
        chk("jz_t_loadBar", loadBar, 8'hFD);
        cycle();
        drive(8'h18, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("jz_n_jumpBar", doJumpBar, 1'b1);
        chk("jz_n_trigger", trigger, 8'h00);
        chk("jz_n_loadBar", loadBar, 8'hFF);
        cycle();

        // opcode 0x70: HALT with the macro, dest 7 load without it
        drive(8'h70, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CONTROL_HALT_EN
        #1 chk("h_loadBar", loadBar, 8'hFF);
        chk("h_trigger", trigger, 8'h00);
        cycle();
        for (int i = 0; i < 3; i++) begin
            #1 chk("h_halted", halted, 1'b1);
            chk("h_fetching", fetching, 1'b0);
            chk("h_loadBar_idle", loadBar, 8'hFF);
            cycle();
        end
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 chk("h_resume", fetching, 1'b1);
        chk("h_released", halted, 1'b0);
`else
        #1 chk("nh_loadBar", loadBar, 8'h7F);
        chk("nh_trigger", trigger, 8'h80);
        cycle();
        #1 chk("nh_halted", halted, 1'b0);
        chk("nh_fetching", fetching, 1'b1);
`endif
        cycle();

        // retired counter wrap
        for (int k = 0; k < 1200 && m_ret != RMOD - 1; k++) begin
            drive(8'($urandom) & 8'hBF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        #1 chk("wrap_pre", retired, RMOD - 1);
        for (int k = 0; k < 4 && m_ret != 0; k++) begin
            drive(8'($urandom) & 8'hBF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            cycle();
        end
        #1 chk("wrap_zero", retired, 0);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            drive(8'($urandom), $urandom_range(0, 3) != 0,
                  1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
